// File: rtl/mmio_dbg_pkg.sv
// Shared constants for the UART-driven MMIO debug master: command opcodes,
// response codes and the controller state encoding.
package mmio_dbg_pkg;

    localparam logic [7:0] OP_WRITE    = 8'h57;
    localparam logic [7:0] OP_READ     = 8'h52;
    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;
    localparam logic [7:0] RSP_BAD_OP  = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ACCESS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mmio_debug_master.sv
// Byte-stream debug master: parses 'W'/'R' commands from a UART receiver,
// performs one MMIO access with timeout, and streams the response back.
module mmio_debug_master
    import mmio_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        mmio_read,
    output logic        mmio_write,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_write_data,
    input  logic        mmio_done,
    input  logic [31:0] mmio_read_data
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_byte_cnt;
    logic        r_is_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_shift;
    logic [15:0] r_tmo_cnt;
    logic        r_read;
    logic        r_write;
    logic        r_out_valid;
    logic [7:0]  r_out_data;

    logic        w_in_ready;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_last_byte;
    logic        w_timeout;
    logic        w_known_op;

    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_timeout   = (r_tmo_cnt == TMO_LAST);
    assign w_known_op  = (in_data == OP_WRITE) || (in_data == OP_READ);

    // NOTE: async reset with non-blocking assignments; every flop, including
    // the shift registers, is reset so outputs are defined during rst.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaults first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_in_ready = !rst;
                if (w_in_fire) begin
                    w_next_state = w_known_op ? ST_ADDR : ST_RESP;
                end
            end
            ST_ADDR: begin
                w_in_ready = !rst;
                if (w_in_fire && w_last_byte) begin
                    w_next_state = r_is_write ? ST_DATA : ST_ACCESS;
                end
            end
            ST_DATA: begin
                w_in_ready = !rst;
                if (w_in_fire && w_last_byte) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mmio_done || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_out_fire && (r_byte_cnt == 2'd0)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt    <= 2'd0;
            r_is_write    <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_rdata_shift <= 32'd0;
            r_tmo_cnt     <= 16'd0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= 8'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_byte_cnt <= 2'd0;
                        r_is_write <= (in_data == OP_WRITE);
                        if (!w_known_op) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= RSP_BAD_OP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_in_fire) begin
                        r_addr     <= {in_data, r_addr[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte && !r_is_write) begin
                            r_read    <= 1'b1;
                            r_tmo_cnt <= 16'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_in_fire) begin
                        r_wdata    <= {in_data, r_wdata[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            r_write   <= 1'b1;
                            r_tmo_cnt <= 16'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Completion outranks a timeout landing on the same edge.
                    if (mmio_done) begin
                        r_read      <= 1'b0;
                        r_write     <= 1'b0;
                        r_out_valid <= 1'b1;
                        if (r_is_write) begin
                            r_out_data <= RSP_OK;
                            r_byte_cnt <= 2'd0;
                        end else begin
                            r_out_data    <= mmio_read_data[7:0];
                            r_rdata_shift <= {8'd0, mmio_read_data[31:8]};
                            r_byte_cnt    <= 2'd3;
                        end
                    end else if (w_timeout) begin
                        r_read      <= 1'b0;
                        r_write     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= RSP_TIMEOUT;
                        r_byte_cnt  <= 2'd0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    // r_byte_cnt holds the number of bytes still to follow.
                    if (w_out_fire) begin
                        if (r_byte_cnt == 2'd0) begin
                            r_out_valid <= 1'b0;
                            r_out_data  <= 8'd0;
                        end else begin
                            r_out_data    <= r_rdata_shift[7:0];
                            r_rdata_shift <= {8'd0, r_rdata_shift[31:8]};
                            r_byte_cnt    <= r_byte_cnt - 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready        = w_in_ready;
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign mmio_read       = r_read;
    assign mmio_write      = r_write;
    assign mmio_addr       = r_addr;
    assign mmio_write_data = r_wdata;

endmodule

// File: tb/tb_mmio_debug_master.sv
// Self-checking bench for mmio_debug_master: transaction-level model of the
// command/response protocol plus directed scenarios with literal expectations.
module tb_mmio_debug_master;

    localparam int TMO = 8;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        mmio_read;
    logic        mmio_write;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_write_data;
    logic        mmio_done;
    logic [31:0] mmio_read_data;

    always #5 sys_clk = ~sys_clk;

    mmio_debug_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .mmio_read       (mmio_read),
        .mmio_write      (mmio_write),
        .mmio_addr       (mmio_addr),
        .mmio_write_data (mmio_write_data),
        .mmio_done       (mmio_done),
        .mmio_read_data  (mmio_read_data)
    );

    typedef struct {
        logic [7:0] data;
        bit         last;
    } rsp_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
    } acc_t;

    int          n_checks = 0;
    int          n_errors = 0;
    rsp_t        exp_rsp[$];
    acc_t        exp_acc[$];
    logic [7:0]  rx_log[$];
    logic [7:0]  cmd_q[$];
    int          n_rx = 0;
    int          done_k;
    logic [31:0] rd_cfg;
    bit          late_pulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Protocol model: what accesses and response bytes the queued command
    // bytes must produce, given how the responder is configured.
    task automatic model_cmds();
        int   i;
        acc_t a;
        rsp_t r;
        bit   ok;
        i = 0;
        while (i < cmd_q.size()) begin
            if (cmd_q[i] == 8'h57 || cmd_q[i] == 8'h52) begin
                a.is_wr = (cmd_q[i] == 8'h57);
                a.addr  = {cmd_q[i+4], cmd_q[i+3], cmd_q[i+2], cmd_q[i+1]};
                a.wdata = a.is_wr ? {cmd_q[i+8], cmd_q[i+7], cmd_q[i+6], cmd_q[i+5]} : 32'd0;
                ok      = (done_k >= 1) && (done_k <= TMO);
                a.hold  = ok ? done_k : TMO;
                exp_acc.push_back(a);
                if (!ok) begin
                    r.data = 8'h54; r.last = 1'b1; exp_rsp.push_back(r);
                end else if (a.is_wr) begin
                    r.data = 8'h4B; r.last = 1'b1; exp_rsp.push_back(r);
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        r.data = rd_cfg[8*k +: 8];
                        r.last = (k == 3);
                        exp_rsp.push_back(r);
                    end
                end
                i += a.is_wr ? 9 : 5;
            end else begin
                r.data = 8'h3F; r.last = 1'b1; exp_rsp.push_back(r);
                i++;
            end
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int  g;
        bit  ok;
        in_valid = 1'b1;
        in_data  = b;
        g = 0;
        do begin
            ok = in_ready;
            @(posedge sys_clk); #1;
            g++;
        end while (!ok && g < 300);
        if (!ok) fail("send_byte_timeout");
        in_valid = 1'b0;
    endtask

    task automatic send_cmds();
        foreach (cmd_q[j]) send_byte(cmd_q[j]);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_rsp.size() != 0 || !in_ready || out_valid) && g < 300) begin
            @(posedge sys_clk); #1;
            g++;
        end
        if (g >= 300) fail("wait_idle_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_mmio_read"}, mmio_read, 0);
        check({tag, "_mmio_write"}, mmio_write, 0);
        check({tag, "_mmio_addr"}, mmio_addr, 0);
        check({tag, "_mmio_wdata"}, mmio_write_data, 0);
    endtask

    // Responder: pulses mmio_done in the done_k-th strobe cycle; read data is
    // only meaningful while mmio_done is high.
    initial begin : responder
        int cnt;
        cnt = 0;
        mmio_done = 1'b0;
        mmio_read_data = 32'hDEADBEEF;
        forever begin
            @(posedge sys_clk); #1;
            if (mmio_read || mmio_write) begin
                cnt++;
                mmio_done      = (cnt == done_k);
                mmio_read_data = (cnt == done_k) ? rd_cfg : 32'hDEADBEEF;
            end else begin
                cnt = 0;
                mmio_read_data = 32'hDEADBEEF;
                mmio_done = late_pulse;
                late_pulse = 1'b0;
            end
        end
    end

    // Compare process: checks response stream and MMIO strobes every cycle.
    initial begin : compare
        bit          prev_hs, prev_last, prev_stall, str_on, st;
        logic [7:0]  prev_od;
        logic [31:0] str_addr, str_wd;
        int          str_len;
        acc_t        cur;
        rsp_t        e;
        prev_hs = 0; prev_last = 0; prev_stall = 0; str_on = 0;
        prev_od = 0; str_len = 0; str_addr = 0; str_wd = 0;
        forever begin
            @(negedge sys_clk);
            if (rst) begin
                prev_hs = 0; prev_stall = 0; str_on = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", out_valid, 1);
                    check("stall_data_held", out_data, prev_od);
                end
                if (prev_hs && !prev_last) check("no_gap_between_bytes", out_valid, 1);
                if (prev_hs && prev_last) begin
                    check("idle_after_resp_in_ready", in_ready, 1);
                    check("idle_after_resp_out_valid", out_valid, 0);
                end
                prev_hs = out_valid && out_ready;
                if (prev_hs) begin
                    if (exp_rsp.size() == 0) begin
                        fail("unexpected_response_byte");
                        prev_last = 1'b1;
                    end else begin
                        e = exp_rsp.pop_front();
                        check("response_byte", out_data, e.data);
                        prev_last = e.last;
                    end
                    rx_log.push_back(out_data);
                    n_rx++;
                end
                prev_stall = out_valid && !out_ready;
                prev_od    = out_data;
                if (out_valid || mmio_read || mmio_write) check("in_ready_low_busy", in_ready, 0);

                st = mmio_read || mmio_write;
                if (st) begin
                    if (mmio_read && mmio_write) fail("both_strobes_high");
                    if (!str_on) begin
                        if (exp_acc.size() == 0) begin
                            fail("unexpected_access");
                            cur.is_wr = mmio_write; cur.hold = -1;
                        end else begin
                            cur = exp_acc.pop_front();
                            check("access_kind", mmio_write, cur.is_wr);
                            check("access_addr", mmio_addr, cur.addr);
                            if (cur.is_wr) check("access_wdata", mmio_write_data, cur.wdata);
                        end
                        str_addr = mmio_addr;
                        str_wd   = mmio_write_data;
                        str_len  = 1;
                    end else begin
                        str_len++;
                        check("addr_stable", mmio_addr, str_addr);
                        check("wdata_stable", mmio_write_data, str_wd);
                        check("kind_stable", mmio_write, cur.is_wr);
                    end
                end else if (str_on) begin
                    check("strobe_length", str_len, cur.hold);
                end
                str_on = st;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "bench watchdog");
    end

    initial begin : main
        int base;
        int g;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        done_k = 0; rd_cfg = 32'd0; late_pulse = 1'b0;

        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        #1 check("in_ready_after_por", in_ready, 1);
        @(posedge sys_clk); #1;

        // Write, done in the third strobe cycle.
        done_k = 3;
        cmd_q = '{8'h57, 8'h20, 8'h01, 8'hFF, 8'hFF, 8'h78, 8'h56, 8'h34, 8'h12};
        model_cmds();
        send_cmds();
        check("w_strobe_next_cycle", mmio_write, 1);
        check("w_no_read", mmio_read, 0);
        check("w_addr_literal", mmio_addr, 32'hFFFF0120);
        check("w_data_literal", mmio_write_data, 32'h12345678);
        wait_idle();
        check("w_resp_literal", rx_log[$], 8'h4B);

        // Read with a 5-cycle out_ready stall mid-stream.
        done_k = 2; rd_cfg = 32'hA1B2C3D4;
        cmd_q = '{8'h52, 8'h24, 8'h01, 8'hFF, 8'hFF};
        model_cmds();
        send_cmds();
        check("r_strobe_next_cycle", mmio_read, 1);
        check("r_addr_literal", mmio_addr, 32'hFFFF0124);
        base = n_rx; g = 0;
        while (n_rx < base + 2 && g < 100) begin @(posedge sys_clk); #1; g++; end
        if (g >= 100) fail("r_first_bytes_timeout");
        out_ready = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1 out_ready = 1'b1;
        wait_idle();
        check("r_byte_count", n_rx - base, 4);
        check("r_b0_literal", rx_log[base], 8'hD4);
        check("r_b1_literal", rx_log[base+1], 8'hC3);
        check("r_b2_literal", rx_log[base+2], 8'hB2);
        check("r_b3_literal", rx_log[base+3], 8'hA1);

        // Read that never completes, then a stray late done pulse.
        done_k = 0;
        cmd_q = '{8'h52, 8'h00, 8'h10, 8'h00, 8'h00};
        model_cmds();
        send_cmds();
        wait_idle();
        check("tmo_resp_literal", rx_log[$], 8'h54);
        late_pulse = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        check("late_done_out_valid", out_valid, 0);
        check("late_done_in_ready", in_ready, 1);
        check("late_done_no_strobe", mmio_read, 0);

        // Done arriving in the same cycle the timeout would fire.
        done_k = TMO; rd_cfg = 32'h55AA00FF;
        cmd_q = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h40};
        model_cmds();
        send_cmds();
        wait_idle();
        check("done_wins_last_byte", rx_log[$], 8'h55);

        // Unknown opcode followed directly by a read.
        done_k = 1; rd_cfg = 32'h0BADF00D;
        cmd_q = '{8'h00, 8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        model_cmds();
        base = n_rx;
        send_cmds();
        wait_idle();
        check("badop_resp_literal", rx_log[base], 8'h3F);
        check("badop_then_read_b0", rx_log[base+1], 8'h0D);
        check("badop_then_read_b3", rx_log[base+4], 8'h0B);

        // Reset in the middle of the write-data phase.
        cmd_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22};
        send_cmds();
        rst = 1'b1;
        @(posedge sys_clk); #1;
        check_reset_outputs("rst_data");
        rst = 1'b0;
        #1 check("in_ready_after_rst_data", in_ready, 1);
        @(posedge sys_clk); #1;

        // Reset while a read response is stalled.
        out_ready = 1'b0; done_k = 2; rd_cfg = 32'h01020304;
        cmd_q = '{8'h52, 8'h44, 8'h00, 8'h00, 8'h00};
        model_cmds();
        send_cmds();
        g = 0;
        while (!out_valid && g < 100) begin @(posedge sys_clk); #1; g++; end
        if (g >= 100) fail("resp_before_rst_timeout");
        repeat (2) @(posedge sys_clk);
        #1;
        rst = 1'b1;
        exp_rsp.delete();
        exp_acc.delete();
        @(posedge sys_clk); #1;
        check_reset_outputs("rst_resp");
        rst = 1'b0; out_ready = 1'b1;
        #1 check("in_ready_after_rst_resp", in_ready, 1);
        @(posedge sys_clk); #1;

        // Full write after the resets completes normally.
        done_k = 1;
        cmd_q = '{8'h57, 8'h04, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
        model_cmds();
        base = n_rx;
        send_cmds();
        check("post_rst_w_addr", mmio_addr, 32'h00000004);
        check("post_rst_w_data", mmio_write_data, 32'hCAFEBABE);
        wait_idle();
        check("post_rst_w_count", n_rx - base, 1);
        check("post_rst_w_resp", rx_log[$], 8'h4B);
        check("all_accesses_seen", exp_acc.size(), 0);

        repeat (3) @(posedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_debug_master.md
MMIO_DEBUG_MASTER -- requirements
Module: mmio_debug_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1023, maximum cycles to wait for mmio_done before abort (1..65535).
REQ-002 SHALL have port: sys_clk  input  1  single clock; every flop on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  command byte available (from UART receiver).
REQ-005 SHALL have port: in_data  input  8  command byte.
REQ-006 SHALL have port: in_ready  output  1  command byte accepted when in_valid && in_ready.
REQ-007 SHALL have port: out_valid  output  1  response byte available (to UART transmitter).
REQ-008 SHALL have port: out_data  output  8  response byte.
REQ-009 SHALL have port: out_ready  input  1  response byte consumed when out_valid && out_ready.
REQ-010 SHALL have port: mmio_read  output  1  read strobe, held until completion.
REQ-011 SHALL have port: mmio_write  output  1  write strobe, held until completion.
REQ-012 SHALL have port: mmio_addr  output  32  access address.
REQ-013 SHALL have port: mmio_write_data  output  32  write data.
REQ-014 SHALL have port: mmio_done  input  1  one-cycle completion pulse from responder.
REQ-015 SHALL have port: mmio_read_data  input  32  read data, valid while mmio_done high.

Function
REQ-016 SHALL parse commands: 0x57 'W' + 4 addr bytes + 4 data bytes (LSB first) -> write; 0x52 'R' + 4 addr bytes (LSB first) -> read.
REQ-017 SHALL, on any other opcode byte, consume only that byte and respond with the single byte 0x3F.
REQ-018 SHALL implement states IDLE -> ADDR(4 bytes) -> [DATA(4 bytes), write only] -> ACCESS -> RESP -> IDLE, with a 2-bit byte counter wrapping 3->0 on leaving ADDR/DATA.
REQ-019 SHALL drive in_ready=1 only in IDLE, ADDR and DATA; in_ready=0 in ACCESS and RESP.
REQ-020 SHALL assert exactly one of mmio_read/mmio_write in the cycle after the final command byte is accepted, with mmio_addr/mmio_write_data stable for the whole access.
REQ-021 SHALL deassert the strobe on the clock edge at which mmio_done is sampled high, and capture mmio_read_data on that same edge.
REQ-022 SHALL count ACCESS cycles; when the count reaches TIMEOUT_CYCLES with no mmio_done, drop the strobe and respond with the single byte 0x54.
REQ-023 SHALL treat mmio_done and timeout in the same cycle as completion (done wins).
REQ-024 SHALL respond on success: write -> the single byte 0x4B; read -> 4 data bytes, LSB first.
REQ-025 SHALL hold out_data stable while out_valid && !out_ready, and advance to the next byte one cycle after each accepted byte, with no idle cycle between bytes.
REQ-026 SHALL return to IDLE in the cycle after the last response byte is accepted; in_ready=1 in that next cycle.
REQ-027 SHALL ignore mmio_done outside ACCESS.

Reset
REQ-028 SHALL, while rst is high, force state IDLE, all counters 0, and mmio_read=mmio_write=0, mmio_addr=mmio_write_data=0, out_valid=0, out_data=0, in_ready=0.
REQ-029 SHALL discard any partial command or pending response on reset mid-operation, and SHALL raise in_ready in the first cycle after rst deasserts.

Structure
REQ-030 SHALL place opcode/response byte constants (0x57, 0x52, 0x4B, 0x54, 0x3F) and the state encoding in shared package mmio_dbg_pkg.
REQ-031 SHALL be a single module with no sub-modules; address, data and response shift registers are implemented inline.

Verification
REQ-032 SHALL cover: bytes 57 20 01 FF FF 78 56 34 12 -> mmio_write with addr 0xFFFF0120 and data 0x12345678; done after 3 cycles -> response 4B.
REQ-033 SHALL cover: bytes 52 24 01 FF FF, done with read_data 0xA1B2C3D4 -> response D4 C3 B2 A1; out_ready low for 5 cycles mid-stream -> no byte lost or duplicated.
REQ-034 SHALL cover: TIMEOUT_CYCLES=8, read with no done -> strobe low after 8 ACCESS cycles, response 54; a late done pulse is then ignored.
REQ-035 SHALL cover: opcode 0x00 followed by a valid 'R' command -> response 3F, then a correct read response.
REQ-036 SHALL cover: rst pulse during DATA and again during RESP -> all outputs 0; a following full 'W' command completes normally.
